instr_seq_fsm: RTL

- Parametrised successor of the team's single-nibble instruction FSM.
- Accepts one 2*HALF_W-bit instruction over a valid/ready handshake and splits it into operands a (low half) and b (high half).
- Mixes the operands over a fixed, parametrised number of PROCESS cycles, then returns the result and a flag over a second valid/ready handshake.
- Sits between the instruction fetch stage and the downstream consumer; backpressure is supported on both sides.

---
 rtl/instr_seq_pkg.sv | 28 ++
 rtl/instr_seq_if.sv | 23 ++
 rtl/instr_seq_datapath.sv | 63 ++++++
 rtl/instr_seq_fsm.sv | 128 ++++++++++++
 4 files changed

// File: rtl/instr_seq_pkg.sv
// Shared types and helpers for the instruction sequencer.
// State encoding, the FSM state type and a width-parametrised rotate-left.
package instr_seq_pkg;

    localparam int MAX_HALF_W = 16;

    localparam logic [1:0] ENC_IDLE    = 2'b00;
    localparam logic [1:0] ENC_CAPTURE = 2'b01;
    localparam logic [1:0] ENC_PROCESS = 2'b10;
    localparam logic [1:0] ENC_EMIT    = 2'b11;

    typedef enum logic [1:0] {
        IDLE    = ENC_IDLE,
        CAPTURE = ENC_CAPTURE,
        PROCESS = ENC_PROCESS,
        EMIT    = ENC_EMIT
    } state_t;

    // Rotate the low w bits of v left by one; bits at and above w must be zero
    // on entry and are zero on return.
    function automatic logic [MAX_HALF_W-1:0] rotl1(input logic [MAX_HALF_W-1:0] v,
                                                    input int unsigned w);
        logic [MAX_HALF_W-1:0] mask;
        mask = MAX_HALF_W'((32'd1 << w) - 32'd1);
        return ((v << 1) | (v >> (w - 1))) & mask;
    endfunction

endpackage

// File: rtl/instr_seq_if.sv
// Instruction-in / result-out handshake bundle for instr_seq_fsm.
// master: the producer/consumer side; slave: the sequencer itself.
interface instr_seq_if #(
    parameter int HALF_W = 4
);
    logic                in_valid;
    logic                in_ready;
    logic [2*HALF_W-1:0] instr_i;
    logic                out_valid;
    logic                out_ready;
    logic [2*HALF_W-1:0] instr_o;
    logic                flag;

    modport master (
        output in_valid, instr_i, out_ready,
        input  in_ready, out_valid, instr_o, flag
    );

    modport slave (
        input  in_valid, instr_i, out_ready,
        output in_ready, out_valid, instr_o, flag
    );
endinterface

// File: rtl/instr_seq_datapath.sv
// Operand registers, mix/rotate logic and result formatting.
// Driven entirely by the load/mix/rot/emit strobes from the sequencer FSM.
module instr_seq_datapath
    import instr_seq_pkg::*;
#(
    parameter int HALF_W = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load,
    input  logic                mix,
    input  logic                rot,
    input  logic                emit,
    input  logic [2*HALF_W-1:0] instr_i,
    output logic [2*HALF_W-1:0] instr_o,
    output logic                flag
);

    logic [HALF_W-1:0] a;
    logic [HALF_W-1:0] b;
    logic [HALF_W-1:0] c;
    logic [HALF_W-1:0] c_nxt;
    logic              mode;

    // Next value of the mix register; emit formats from this so the last rotate is included.
    always_comb begin
        c_nxt = c;
        if (mix) begin
            c_nxt = (a & b) ^ (a | b);
        end else if (rot) begin
            c_nxt = HALF_W'(rotl1(MAX_HALF_W'(c), HALF_W));
        end
    end

    // Operand capture and mix register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a    <= '0;
            b    <= '0;
            c    <= '0;
            mode <= 1'b0;
        end else begin
            if (load) begin
                a    <= instr_i[HALF_W-1:0];
                b    <= instr_i[2*HALF_W-1:HALF_W];
                mode <= instr_i[0];
            end
            c <= c_nxt;
        end
    end

    // Result register, loaded once on entry to EMIT and held afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_o <= '0;
            flag    <= 1'b0;
        end else if (emit) begin
            instr_o <= mode ? {a, c_nxt} : {{HALF_W{1'b0}}, c_nxt};
            flag    <= c_nxt[0] ^ mode;
        end
    end

endmodule

// File: rtl/instr_seq_fsm.sv
// Instruction sequencer: accept, mix for HOLD_CYCLES cycles, emit result.
// Optional completion counter on done_cnt when INSTR_SEQ_PERF_CNT_EN is defined.
module instr_seq_fsm
    import instr_seq_pkg::*;
#(
    parameter int HALF_W      = 4,
    parameter int HOLD_CYCLES = 2,
    parameter int CNT_W       = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    instr_seq_if.slave  bus,
    output logic        busy
`ifdef INSTR_SEQ_PERF_CNT_EN
    ,
    output logic [15:0] done_cnt
`endif
);

    state_t              state;
    state_t              state_n;
    logic [CNT_W-1:0]    cnt;
    logic [CNT_W-1:0]    cnt_n;
    logic                out_valid_q;
    logic                out_valid_n;
    logic                load;
    logic                mix;
    logic                rot;
    logic                emit;
    logic [2*HALF_W-1:0] instr_o_w;
    logic                flag_w;

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.instr_o   = instr_o_w;
    assign bus.flag      = flag_w;

    // State, counter and registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            out_valid_q <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            out_valid_q <= out_valid_n;
            busy        <= (state_n != IDLE);
        end
    end

    // Next-state, counter and datapath strobes.
    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        out_valid_n = out_valid_q;
        load        = 1'b0;
        mix         = 1'b0;
        rot         = 1'b0;
        emit        = 1'b0;
        case (state)
            IDLE: begin
                if (bus.in_valid) begin
                    load    = 1'b1;
                    state_n = CAPTURE;
                end
            end
            CAPTURE: begin
                mix   = 1'b1;
                cnt_n = CNT_W'(HOLD_CYCLES);
                if (HOLD_CYCLES > 0) begin
                    state_n = PROCESS;
                end else begin
                    emit        = 1'b1;
                    out_valid_n = 1'b1;
                    state_n     = EMIT;
                end
            end
            PROCESS: begin
                rot   = 1'b1;
                cnt_n = cnt - CNT_W'(1);
                // <= rather than == so a corrupted zero count cannot spin forever
                if (cnt <= CNT_W'(1)) begin
                    emit        = 1'b1;
                    out_valid_n = 1'b1;
                    state_n     = EMIT;
                end
            end
            EMIT: begin
                if (bus.out_ready) begin
                    out_valid_n = 1'b0;
                    state_n     = IDLE;
                end
            end
            default: begin
                out_valid_n = 1'b0;
                state_n     = IDLE;
            end
        endcase
    end

`ifdef INSTR_SEQ_PERF_CNT_EN
    // Count completed result handshakes, wrapping at 16 bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_cnt <= '0;
        end else if (out_valid_q && bus.out_ready) begin
            done_cnt <= done_cnt + 16'd1;
        end
    end
`endif

    instr_seq_datapath #(
        .HALF_W (HALF_W)
    ) u_dp (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (load),
        .mix     (mix),
        .rot     (rot),
        .emit    (emit),
        .instr_i (bus.instr_i),
        .instr_o (instr_o_w),
        .flag    (flag_w)
    );

endmodule
